// File: rtl/axis_frame_arbiter.sv
// rtl/axis_frame_arbiter.sv - two-source frame-atomic AXIS arbiter with registered output and frame counter
module axis_frame_arbiter #(
  parameter int WIDTH = 8,
  parameter int CBITS = 16
) (
  input  logic             m_clock,
  input  logic             s_reset,
  input  logic             s0_tvalid,
  output logic             s0_tready,
  input  logic             s0_tlast,
  input  logic [WIDTH-1:0] s0_tdata,
  input  logic             s1_tvalid,
  output logic             s1_tready,
  input  logic             s1_tlast,
  input  logic [WIDTH-1:0] s1_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [WIDTH-1:0] m_tdata,
  output logic [1:0]       grant,
  output logic [CBITS-1:0] frames
);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2} state_t;

  state_t state;
  logic   ptr;
  logic   out_free;
  logic   accept0;
  logic   accept1;

  // Output register can take a beat when empty or draining this cycle.
  assign out_free  = !m_tvalid || m_tready;
  assign s0_tready = !s_reset && (state == GRANT0) && out_free;
  assign s1_tready = !s_reset && (state == GRANT1) && out_free;
  assign accept0   = s0_tvalid && s0_tready;
  assign accept1   = s1_tvalid && s1_tready;
  assign grant     = {state == GRANT1, state == GRANT0};

  always_ff @(posedge m_clock) begin
    if (s_reset) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tdata  <= '0;
      frames   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // ptr=0 favours src0, ptr=1 favours src1 when both request.
          if (s0_tvalid && (!s1_tvalid || !ptr)) state <= GRANT0;
          else if (s1_tvalid)                     state <= GRANT1;
        end
        GRANT0: begin
          if (accept0 && s0_tlast) begin
            state <= IDLE;
            ptr   <= 1'b1;
          end
        end
        GRANT1: begin
          if (accept1 && s1_tlast) begin
            state <= IDLE;
            ptr   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (accept0) begin
        m_tvalid <= 1'b1;
        m_tlast  <= s0_tlast;
        m_tdata  <= s0_tdata;
      end else if (accept1) begin
        m_tvalid <= 1'b1;
        m_tlast  <= s1_tlast;
        m_tdata  <= s1_tdata;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end

      if (m_tvalid && m_tready && m_tlast) frames <= frames + 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// tb/tb_axis_frame_arbiter.sv - vector table plus sequence checks for axis_frame_arbiter
module tb_axis_frame_arbiter;

  logic       m_clock;
  logic       s_reset;
  logic       s0_tvalid, s0_tready, s0_tlast;
  logic [7:0] s0_tdata;
  logic       s1_tvalid, s1_tready, s1_tlast;
  logic [7:0] s1_tdata;
  logic       m_tvalid, m_tready, m_tlast;
  logic [7:0] m_tdata;
  logic [1:0] grant;
  logic [3:0] frames;

  axis_frame_arbiter #(.WIDTH(8), .CBITS(4)) dut (
    .m_clock(m_clock), .s_reset(s_reset),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tlast(s0_tlast), .s0_tdata(s0_tdata),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tlast(s1_tlast), .s1_tdata(s1_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tdata(m_tdata),
    .grant(grant), .frames(frames)
  );

  initial m_clock = 1'b0;
  always #5 m_clock = ~m_clock;

  typedef struct {
    bit       rst, s0v, s0l;
    bit [7:0] s0d;
    bit       s1v, s1l;
    bit [7:0] s1d;
    bit       rdy;
    bit [1:0] g;
    bit       mv, ml;
    bit [7:0] md;
    bit       r0, r1;
    bit [3:0] fr;
  } vec_t;

  vec_t       tbl[$];
  int         checks = 0;
  int         errors = 0;
  logic [8:0] q0[$], q1[$], rx[$], exp_q[$];
  bit         prev_stall;
  logic [8:0] prev_beat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input bit r, s0v, s0l, input bit [7:0] s0d, input bit s1v, s1l,
                     input bit [7:0] s1d, input bit rd, input bit [1:0] g, input bit mv, ml,
                     input bit [7:0] md, input bit r0, r1, input bit [3:0] fr);
    vec_t v;
    v.rst = r; v.s0v = s0v; v.s0l = s0l; v.s0d = s0d; v.s1v = s1v; v.s1l = s1l; v.s1d = s1d;
    v.rdy = rd; v.g = g; v.mv = mv; v.ml = ml; v.md = md; v.r0 = r0; v.r1 = r1; v.fr = fr;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    s_reset = 1; s0_tvalid = 0; s0_tlast = 0; s0_tdata = 0;
    s1_tvalid = 0; s1_tlast = 0; s1_tdata = 0; m_tready = 1;
    @(posedge m_clock); #1;
    s_reset = 0;
    prev_stall = 0;
    q0.delete(); q1.delete(); rx.delete(); exp_q.delete();
  endtask

  // One cycle of queue-driven sources and a recording sink.
  task automatic cycle(input bit rdy);
    bit hs0, hs1;
    s0_tvalid = q0.size() > 0;
    {s0_tlast, s0_tdata} = (q0.size() > 0) ? q0[0] : 9'h0;
    s1_tvalid = q1.size() > 0;
    {s1_tlast, s1_tdata} = (q1.size() > 0) ? q1[0] : 9'h0;
    m_tready = rdy;
    @(negedge m_clock);
    hs0 = s0_tvalid && s0_tready;
    hs1 = s1_tvalid && s1_tready;
    if (hs0) chk("grant_on_s0_beat", grant, 2'b01);
    if (hs1) chk("grant_on_s1_beat", grant, 2'b10);
    if (prev_stall) chk("hold_while_stalled", {m_tlast, m_tdata}, prev_beat);
    prev_stall = m_tvalid && !m_tready;
    prev_beat  = {m_tlast, m_tdata};
    if (m_tvalid && m_tready) rx.push_back({m_tlast, m_tdata});
    @(posedge m_clock); #1;
    if (hs0) void'(q0.pop_front());
    if (hs1) void'(q1.pop_front());
  endtask

  task automatic run(input int want, input int mode);
    int c = 0;
    while (rx.size() < want && c < 400) begin
      cycle(mode == 0 ? 1'b1 : (c % 3 == 0));
      c++;
    end
    if (rx.size() < want) chk("run_timeout_beats", rx.size(), want);
    cycle(1'b1);
    chk("beat_count", rx.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < rx.size()) chk($sformatf("beat%0d", i), rx[i], exp_q[i]);
  endtask

  initial begin
    //  r s0v s0l s0d   s1v s1l s1d   rdy  g  mv ml md    r0 r1 fr
    add(1, 0, 0, 8'h00, 0, 0, 8'h00, 1,  0, 0, 0, 8'h00, 0, 0, 0);
    add(0, 1, 0, 8'h11, 0, 0, 8'h00, 1,  1, 0, 0, 8'h00, 1, 0, 0);
    add(0, 1, 0, 8'h11, 0, 0, 8'h00, 1,  1, 1, 0, 8'h11, 1, 0, 0);
    add(0, 1, 0, 8'h22, 0, 0, 8'h00, 1,  1, 1, 0, 8'h22, 1, 0, 0);
    add(0, 1, 0, 8'h33, 0, 0, 8'h00, 1,  1, 1, 0, 8'h33, 1, 0, 0);
    add(0, 1, 1, 8'h44, 0, 0, 8'h00, 1,  0, 1, 1, 8'h44, 0, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 8'h00, 1,  0, 0, 1, 8'h44, 0, 0, 1);
    add(1, 1, 0, 8'ha1, 1, 0, 8'hb1, 1,  0, 0, 0, 8'h00, 0, 0, 0);
    add(0, 1, 0, 8'ha1, 1, 0, 8'hb1, 1,  1, 0, 0, 8'h00, 1, 0, 0);
    add(0, 1, 0, 8'ha1, 1, 0, 8'hb1, 1,  1, 1, 0, 8'ha1, 1, 0, 0);
    add(0, 1, 0, 8'ha2, 1, 0, 8'hb1, 1,  1, 1, 0, 8'ha2, 1, 0, 0);
    add(0, 1, 1, 8'ha3, 1, 0, 8'hb1, 1,  0, 1, 1, 8'ha3, 0, 0, 0);
    add(0, 1, 0, 8'hc1, 1, 0, 8'hb1, 1,  2, 0, 1, 8'ha3, 0, 1, 1);
    add(0, 1, 0, 8'hc1, 1, 0, 8'hb1, 1,  2, 1, 0, 8'hb1, 0, 1, 1);
    add(0, 1, 0, 8'hc1, 1, 0, 8'hb2, 1,  2, 1, 0, 8'hb2, 0, 1, 1);
    add(0, 1, 0, 8'hc1, 1, 1, 8'hb3, 1,  0, 1, 1, 8'hb3, 0, 0, 1);
    add(0, 0, 0, 8'h00, 0, 0, 8'h00, 1,  0, 0, 1, 8'hb3, 0, 0, 2);
    add(1, 0, 0, 8'h00, 0, 0, 8'h00, 1,  0, 0, 0, 8'h00, 0, 0, 0);
    add(0, 1, 0, 8'h51, 1, 1, 8'h61, 1,  1, 0, 0, 8'h00, 1, 0, 0);
    add(0, 1, 0, 8'h51, 1, 1, 8'h61, 1,  1, 1, 0, 8'h51, 1, 0, 0);
    add(0, 0, 0, 8'h00, 1, 1, 8'h61, 1,  1, 0, 0, 8'h51, 1, 0, 0);
    add(0, 0, 0, 8'h00, 1, 1, 8'h61, 1,  1, 0, 0, 8'h51, 1, 0, 0);
    add(0, 0, 0, 8'h00, 1, 1, 8'h61, 1,  1, 0, 0, 8'h51, 1, 0, 0);
    add(0, 1, 0, 8'h52, 1, 1, 8'h61, 1,  1, 1, 0, 8'h52, 1, 0, 0);
    add(1, 1, 1, 8'h53, 1, 1, 8'h61, 1,  0, 0, 0, 8'h00, 0, 0, 0);
    add(0, 0, 0, 8'h00, 1, 1, 8'h61, 1,  2, 0, 0, 8'h00, 0, 1, 0);
    add(0, 0, 0, 8'h00, 1, 1, 8'h61, 1,  0, 1, 1, 8'h61, 0, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 8'h00, 1,  0, 0, 1, 8'h61, 0, 0, 1);

    foreach (tbl[i]) begin
      s_reset = tbl[i].rst;
      s0_tvalid = tbl[i].s0v; s0_tlast = tbl[i].s0l; s0_tdata = tbl[i].s0d;
      s1_tvalid = tbl[i].s1v; s1_tlast = tbl[i].s1l; s1_tdata = tbl[i].s1d;
      m_tready = tbl[i].rdy;
      @(posedge m_clock); #1;
      chk($sformatf("v%0d_grant", i), grant, tbl[i].g);
      chk($sformatf("v%0d_m_tvalid", i), m_tvalid, tbl[i].mv);
      chk($sformatf("v%0d_m_tlast", i), m_tlast, tbl[i].ml);
      chk($sformatf("v%0d_m_tdata", i), m_tdata, tbl[i].md);
      chk($sformatf("v%0d_s0_tready", i), s0_tready, tbl[i].r0);
      chk($sformatf("v%0d_s1_tready", i), s1_tready, tbl[i].r1);
      chk($sformatf("v%0d_frames", i), frames, tbl[i].fr);
    end

    // Fairness: both sources always have 2-beat frames queued.
    do_reset();
    for (int f = 0; f < 4; f++)
      for (int b = 0; b < 2; b++) begin
        q0.push_back({b == 1, 8'(f * 2 + b)});
        q1.push_back({b == 1, 8'(8'h80 + f * 2 + b)});
      end
    for (int f = 0; f < 4; f++) begin
      for (int b = 0; b < 2; b++) exp_q.push_back({b == 1, 8'(f * 2 + b)});
      for (int b = 0; b < 2; b++) exp_q.push_back({b == 1, 8'(8'h80 + f * 2 + b)});
    end
    run(16, 0);
    chk("fair_frames", frames, 4'd8);

    // Backpressure on a 5-beat src1 frame.
    do_reset();
    for (int b = 0; b < 5; b++) begin
      q1.push_back({b == 4, 8'(8'hd0 + b)});
      exp_q.push_back({b == 4, 8'(8'hd0 + b)});
    end
    run(5, 1);
    chk("bp_frames", frames, 4'd1);

    // 17 single-beat frames wrap the 4-bit counter to 1.
    do_reset();
    for (int n = 0; n < 17; n++) begin
      q0.push_back({1'b1, 8'(n)});
      exp_q.push_back({1'b1, 8'(n)});
    end
    run(17, 0);
    chk("wrap_frames", frames, 4'd1);
    chk("wrap_grant_idle", grant, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
